// File: rtl/shift_sequencer.sv
// shift_sequencer: drives a single-step 8-bit shifter for AMT cycles,
// feeding each result back, behind a START/BUSY/DONE handshake.
module shift_sequencer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic [2:0] OP,
    input  logic [2:0] AMT,
    input  logic [7:0] DIN,
    input  logic       CIN,
    output logic [2:0] HSEL,
    output logic [7:0] F,
    output logic       CI,
    input  logic [7:0] S,
    input  logic       CO,
    output logic [7:0] DOUT,
    output logic       COUT,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wreg_q, wreg_d;
    logic       creg_q, creg_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] opreg_q, opreg_d;
    logic [7:0] dout_q, dout_d;
    logic       cout_q, cout_d;
    logic       carry_op;

    // Only the two through-carry rotates update the carry register.
    assign carry_op = (opreg_q == 3'b100) || (opreg_q == 3'b111);

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            wreg_q  <= 8'h00;
            creg_q  <= 1'b0;
            cnt_q   <= 3'd0;
            opreg_q <= 3'b000;
            dout_q  <= 8'h00;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wreg_q  <= wreg_d;
            creg_q  <= creg_d;
            cnt_q   <= cnt_d;
            opreg_q <= opreg_d;
            dout_q  <= dout_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and datapath update; everything holds by default.
    always_comb begin
        state_d = state_q;
        wreg_d  = wreg_q;
        creg_d  = creg_q;
        cnt_d   = cnt_q;
        opreg_d = opreg_q;
        dout_d  = dout_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    wreg_d  = DIN;
                    creg_d  = CIN;
                    opreg_d = OP;
                    cnt_d   = AMT;
                    if (AMT != 3'd0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        dout_d  = DIN;
                        cout_d  = CIN;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else begin
                    wreg_d = S;
                    if (carry_op) creg_d = CO;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        dout_d  = S;
                        cout_d  = carry_op ? CO : creg_q;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Shifter select is only live while stepping.
    always_comb begin
        HSEL = (state_q == ST_SHIFT) ? opreg_q : 3'b000;
        F    = wreg_q;
        CI   = creg_q;
        DOUT = dout_q;
        COUT = cout_q;
        BUSY = (state_q == ST_SHIFT) || (state_q == ST_DONE);
        DONE = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed commands against a behavioural shifter,
// with a queue of expected results checked on every DONE pulse.
module tb_shift_sequencer;

    logic       CLK = 1'b0;
    logic       RST, START, ABORT, CIN, CI, CO, COUT, BUSY, DONE;
    logic [2:0] OP, AMT, HSEL;
    logic [7:0] DIN, F, S, DOUT;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    always #5 CLK = ~CLK;

    shift_sequencer dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .OP(OP), .AMT(AMT), .DIN(DIN), .CIN(CIN),
        .HSEL(HSEL), .F(F), .CI(CI), .S(S), .CO(CO),
        .DOUT(DOUT), .COUT(COUT), .BUSY(BUSY), .DONE(DONE)
    );

    // Single-position shifter, combinational.
    always_comb begin
        S  = F;
        CO = 1'b0;
        case (HSEL)
            3'b000: S = F;
            3'b001: begin S = {F[6:0], 1'b0}; CO = F[7]; end
            3'b010: begin S = {1'b0, F[7:1]}; CO = F[0]; end
            3'b011: S = 8'h00;
            3'b100: {CO, S} = {F, CI};
            3'b101: begin S = {F[6:0], F[7]}; CO = F[7]; end
            3'b110: begin S = {F[0], F[7:1]}; CO = F[0]; end
            3'b111: {S, CO} = {CI, F};
            default: S = F;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest pending result.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("dout", {24'h0, DOUT}, {24'h0, e[8:1]});
                chk("cout", {31'h0, COUT}, {31'h0, e[0]});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] din,
                           input logic cin, input logic [2:0] amt,
                           input logic [7:0] edout, input logic ecout,
                           input int poke, input bit mid,
                           input logic [7:0] mid_f, input logic mid_ci);
        int n;
        exp_q.push_back({edout, ecout});
        OP = op; DIN = din; CIN = cin; AMT = amt; START = 1'b1;
        tick();
        START = 1'b0;
        chk("busy_start", {31'h0, BUSY}, 32'd1);
        n = 0;
        while (DONE !== 1'b1 && n < 20) begin
            chk("hsel_shift", {29'h0, HSEL}, {29'h0, op});
            if (mid && n == 1) begin
                chk("mid_f", {24'h0, F}, {24'h0, mid_f});
                chk("mid_ci", {31'h0, CI}, {31'h0, mid_ci});
            end
            if (n == poke) begin
                START = 1'b1;
                DIN   = 8'hFF;
            end
            tick();
            START = 1'b0;
            n++;
        end
        chk("latency", n, {29'h0, amt});
        chk("hsel_done", {29'h0, HSEL}, 32'd0);
        chk("busy_done", {31'h0, BUSY}, 32'd1);
        tick();
        chk("done_low", {31'h0, DONE}, 32'd0);
        chk("busy_low", {31'h0, BUSY}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; ABORT = 1'b0;
        OP = 3'b000; AMT = 3'd0; DIN = 8'h00; CIN = 1'b0;
        #12;
        chk("rst_dout", {24'h0, DOUT}, 32'd0);
        chk("rst_busy", {31'h0, BUSY}, 32'd0);
        chk("rst_done", {31'h0, DONE}, 32'd0);
        chk("rst_hsel", {29'h0, HSEL}, 32'd0);
        tick();
        RST = 1'b0;

        run_cmd(3'b101, 8'h81, 1'b0, 3'd3, 8'h0C, 1'b0,
                -1, 1'b0, 8'h00, 1'b0);
        run_cmd(3'b100, 8'hA5, 1'b1, 3'd2, 8'h97, 1'b0,
                -1, 1'b1, 8'h4B, 1'b1);
        run_cmd(3'b111, 8'h01, 1'b0, 3'd1, 8'h00, 1'b1,
                -1, 1'b0, 8'h00, 1'b0);
        run_cmd(3'b001, 8'h3C, 1'b1, 3'd0, 8'h3C, 1'b1,
                -1, 1'b0, 8'h00, 1'b0);
        run_cmd(3'b010, 8'hF0, 1'b0, 3'd7, 8'h01, 1'b0,
                3, 1'b0, 8'h00, 1'b0);
        run_cmd(3'b000, 8'h5A, 1'b0, 3'd1, 8'h5A, 1'b0,
                -1, 1'b0, 8'h00, 1'b0);

        // ABORT wins over START in IDLE.
        OP = 3'b001; DIN = 8'h77; AMT = 3'd2;
        START = 1'b1; ABORT = 1'b1;
        tick();
        START = 1'b0; ABORT = 1'b0;
        chk("abort_idle_busy", {31'h0, BUSY}, 32'd0);

        // ABORT after two steps of a ror.
        OP = 3'b110; DIN = 8'h55; CIN = 1'b1; AMT = 3'd5; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (2) tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_busy", {31'h0, BUSY}, 32'd0);
        chk("abort_done", {31'h0, DONE}, 32'd0);
        chk("abort_dout", {24'h0, DOUT}, 32'h5A);
        chk("abort_cout", {31'h0, COUT}, 32'd0);
        repeat (6) tick();

        // Asynchronous reset after three steps.
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (3) tick();
        #2;
        RST = 1'b1;
        #1;
        chk("arst_busy", {31'h0, BUSY}, 32'd0);
        chk("arst_done", {31'h0, DONE}, 32'd0);
        chk("arst_dout", {24'h0, DOUT}, 32'd0);
        chk("arst_cout", {31'h0, COUT}, 32'd0);
        chk("arst_hsel", {29'h0, HSEL}, 32'd0);
        chk("arst_f", {24'h0, F}, 32'd0);
        chk("arst_ci", {31'h0, CI}, 32'd0);
        tick();
        RST = 1'b0;

        run_cmd(3'b110, 8'h55, 1'b1, 3'd5, 8'hAA, 1'b1,
                -1, 1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
